rr_req_gnt_arbiter: RTL and testbench
=====================================

# rr_req_gnt_arbiter

Round-robin request/grant arbiter that shares one resource among `NUM_REQ` requesters using the req/gnt handshake our assertion benches check. It issues a registered one-hot grant one cycle after a request is sampled and holds it while the owner keeps `req` high. A hold-limit timeout forces release so no requester can starve the others. It sits between requesting agents and the shared resource, on a single clock domain.

## Interface
- `NUM_REQ`, default 4: number of requesters, legal range 1..16.
- `MAX_HOLD`, default 16: maximum consecutive grant cycles per tenure; 0 means unlimited.
- `clk`  input  1  clock; all logic is on the rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `req`  input  NUM_REQ  request level per requester.
- `gnt`  output  NUM_REQ  registered grant, one-hot or zero.
- `gnt_valid`  output  1  high when any `gnt` bit is high.
- `gnt_id`  output  max(1,$clog2(NUM_REQ))  index of the current owner; 0 when `gnt_valid`=0.
- `timeout`  output  1  one-cycle pulse when a tenure is cut by `MAX_HOLD`.

## Operation
- State machine has three states:
  - IDLE: no grant.
  - GRANT: `owner` holds `gnt`.
  - PARK: one forced idle cycle after a timeout when no other requester is waiting.
- Internal registers:
  - `ptr`: round-robin start index.
  - `owner`.
  - `hold_cnt`: width `$clog2(MAX_HOLD+1)`.
- Pick rule: the lowest index `i` is chosen by searching `req` from `ptr` upward, wrapping from NUM_REQ-1 to 0. Candidates can be masked (see below).
- IDLE, any `req` high:
  - Next state GRANT; `gnt` is set to the winner, `owner`=winner, `hold_cnt`=1.
  - `ptr`=winner+1 mod NUM_REQ.
- IDLE, no `req`: stay in IDLE.
- GRANT, `req[owner]` high and (`MAX_HOLD`=0 or `hold_cnt`<`MAX_HOLD`): hold the grant and increment `hold_cnt`. With `MAX_HOLD`=0 the counter saturates.
- GRANT, `req[owner]` low:
  - Pick with `owner` masked out.
  - If there is a winner, hand off directly to it (new one-hot `gnt`, `hold_cnt`=1, `ptr` updated).
  - Otherwise go to IDLE with `gnt`=0.
  - No `timeout` pulse.
- GRANT, `req[owner]` high and `hold_cnt`==`MAX_HOLD`:
  - Pulse `timeout`.
  - Pick with `owner` masked out. If there is a winner, hand off to it.
  - Otherwise go to PARK with `gnt`=0.
- PARK: exactly one cycle with `gnt`=0, then behave as IDLE. The previous owner may win again.
- An owner release coinciding with the hold limit counts as a release: no `timeout` pulse.
- With NUM_REQ=1 the pick is trivial; a timeout always passes through PARK.
- Reset:
  - State IDLE; `ptr`=0, `owner`=0, `hold_cnt`=0.
  - `gnt`=0, `gnt_valid`=0, `gnt_id`=0, `timeout`=0.
  - Reset mid-tenure drops `gnt` on the same edge at which `reset` is sampled high.

## Timing
- Grant latency: a `req` sampled high in IDLE or PARK gives `gnt` high at the next edge (req |-> ##1 gnt).
- Release latency: a `req[owner]` sampled low gives the owner's `gnt` low at the next edge.
- A handoff replaces the one-hot grant in a single edge. There is never an overlap, and no gap cycle.
- Maximum tenure is exactly `MAX_HOLD` cycles of `gnt` high.
- `timeout` is registered and is high in the same cycle the cut grant first reads low.
- `gnt_valid` and `gnt_id` are registered alongside `gnt` and are always consistent with it.
- The pick path is combinational: `req` → priority pick → state/gnt registers. There are no other combinational input-to-output paths.

## Structure
- Package `arb_pkg` holds:
  - `arb_state_e` (IDLE, GRANT, PARK).
  - Localparam helpers for the id and counter widths.
- Sub-module `rr_priority_pick`: combinational, parameterized by NUM_REQ.
  - Inputs `req`, `mask`, `ptr`; outputs `found`, `idx`.
  - It is reused by the pick in every state.
- Top level holds the FSM, `hold_cnt`, `ptr` and the output registers.

## Test plan
All scenarios use NUM_REQ=4, MAX_HOLD=4.
- After reset, `req`=4'b0001 at cycle 0 → `gnt`=4'b0001, `gnt_id`=0 at cycle 1. `req[0]` low at cycle 3 → `gnt`=0 at cycle 4.
- `req`=4'b1111 held continuously:
  - grant sequence 0,1,2,3,0, each tenure exactly 4 cycles with no gap;
  - `timeout` pulses at every handoff.
- `req`=4'b0100 held alone:
  - `gnt[2]` high 4 cycles, then one low PARK cycle with `timeout`=1, then `gnt[2]` again;
  - the pattern repeats.
- Owner 1 drops `req` in the cycle `hold_cnt`==4 while `req[3]` is high → direct handoff to 3, `timeout` stays 0.
- `reset` asserted during owner 2's tenure → `gnt`=0 at that edge. After release, with `req`=4'b1100, requester 2 wins because `ptr`=0.
- Throughout all scenarios, an assertion checks that `$onehot0(gnt)` holds every cycle and that req |-> ##1 gnt holds whenever the state is IDLE.

Source files
------------

// File: rtl/arb_pkg.sv
// arb_pkg: shared FSM state type and width helpers for the round-robin arbiter
package arb_pkg;
  typedef enum logic [1:0] {IDLE, GRANT, PARK} arb_state_e;
  function automatic int id_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  function automatic int cnt_w(input int m);
    return m > 0 ? $clog2(m + 1) : 1;
  endfunction
endpackage

// File: rtl/rr_priority_pick.sv
// rr_priority_pick: first unmasked req at or after ptr, wrapping (req, mask, ptr -> found, idx)
module rr_priority_pick
  import arb_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        mask,
  input  logic [id_w(NUM_REQ)-1:0]  ptr,
  output logic                      found,
  output logic [id_w(NUM_REQ)-1:0]  idx
);
  localparam int IW = id_w(NUM_REQ);
  logic [NUM_REQ-1:0] cand;
  assign cand = req & ~mask;
  always_comb begin
    found = 1'b0;
    idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--)
      if (cand[(int'(ptr) + k) % NUM_REQ]) begin
        found = 1'b1;
        idx = IW'((int'(ptr) + k) % NUM_REQ);
      end
  end
endmodule

// File: rtl/rr_req_gnt_arbiter.sv
// rr_req_gnt_arbiter: round-robin req/gnt arbiter with hold limit (clk, reset, req -> gnt, gnt_valid, gnt_id, timeout)
module rr_req_gnt_arbiter
  import arb_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int MAX_HOLD = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  output logic [NUM_REQ-1:0]        gnt,
  output logic                      gnt_valid,
  output logic [id_w(NUM_REQ)-1:0]  gnt_id,
  output logic                      timeout
);
  localparam int IW = id_w(NUM_REQ);
  localparam int CW = cnt_w(MAX_HOLD);
  arb_state_e state;
  logic [IW-1:0] ptr, owner, idx;
  logic [CW-1:0] hold_cnt;
  logic [NUM_REQ-1:0] mask;
  logic found, lim, keep, cut;
  assign mask = state == GRANT ? NUM_REQ'(1) << owner : '0;
  assign lim  = MAX_HOLD != 0 && hold_cnt == CW'(MAX_HOLD);
  assign keep = state == GRANT && req[owner] && !lim;
  assign cut  = state == GRANT && req[owner] && lim;
  rr_priority_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req  (req),
    .mask (mask),
    .ptr  (ptr),
    .found(found),
    .idx  (idx)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ptr <= '0;
      owner <= '0;
      hold_cnt <= '0;
      gnt <= '0;
      gnt_valid <= 1'b0;
      gnt_id <= '0;
      timeout <= 1'b0;
    end else if (keep) begin
      hold_cnt <= &hold_cnt ? hold_cnt : hold_cnt + 1'b1;
      timeout <= 1'b0;
    end else begin
      timeout <= cut;
      if (found) begin
        state <= GRANT;
        owner <= idx;
        ptr <= idx == IW'(NUM_REQ - 1) ? '0 : idx + 1'b1;
        hold_cnt <= CW'(1);
        gnt <= NUM_REQ'(1) << idx;
        gnt_valid <= 1'b1;
        gnt_id <= idx;
      end else begin
        state <= cut ? PARK : IDLE;
        hold_cnt <= '0;
        gnt <= '0;
        gnt_valid <= 1'b0;
        gnt_id <= '0;
      end
    end
  end
endmodule

// File: tb/tb_rr_req_gnt_arbiter.sv
// tb_rr_req_gnt_arbiter: directed and random checks of the arbiter against a behavioural model
module tb_rr_req_gnt_arbiter;
  import arb_pkg::*;
  localparam int N = 4;
  localparam int MH = 4;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [N-1:0] req = '0;
  logic [N-1:0] gnt;
  logic gnt_valid, timeout;
  logic [1:0] gnt_id;
  int n_chk = 0, n_fail = 0;
  int m_st = 0, m_owner = 0, m_ptr = 0, m_cnt = 0, m_to = 0;
  int ten = 0;
  logic [N-1:0] prev_gnt = '0;
  always #5 clk = ~clk;
  rr_req_gnt_arbiter #(.NUM_REQ(N), .MAX_HOLD(MH)) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .gnt      (gnt),
    .gnt_valid(gnt_valid),
    .gnt_id   (gnt_id),
    .timeout  (timeout)
  );
  assert property (@(posedge clk) $onehot0(gnt)) else $error("FAIL onehot0 gnt=%b", gnt);
  assert property (@(posedge clk) disable iff (reset) (dut.state == IDLE && |req) |=> |gnt)
    else $error("FAIL idle_latency gnt=%b", gnt);
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask
  // model states: 0 idle, 1 owner holds, 2 parked
  task automatic model(input logic [N-1:0] r, input logic rs);
    int win;
    bit held;
    if (rs) begin
      m_st = 0; m_owner = 0; m_ptr = 0; m_cnt = 0; m_to = 0;
      return;
    end
    m_to = 0;
    held = m_st == 1 && r[m_owner];
    if (held && m_cnt < MH) begin
      m_cnt++;
      return;
    end
    m_to = held;
    win = -1;
    for (int k = 0; k < N; k++)
      if (win < 0 && r[(m_ptr + k) % N] && !(m_st == 1 && (m_ptr + k) % N == m_owner))
        win = (m_ptr + k) % N;
    if (win >= 0) begin
      m_st = 1; m_owner = win; m_ptr = (win + 1) % N; m_cnt = 1;
    end else begin
      m_st = held ? 2 : 0; m_cnt = 0;
    end
  endtask
  task automatic step(input logic [N-1:0] r, input logic rs);
    logic [N-1:0] eg;
    @(negedge clk);
    req = r;
    reset = rs;
    model(r, rs);
    @(posedge clk);
    #1;
    eg = m_st == 1 ? N'(1) << m_owner : '0;
    check("gnt", 32'(gnt), 32'(eg));
    check("gnt_valid", 32'(gnt_valid), 32'(m_st == 1));
    check("gnt_id", 32'(gnt_id), m_st == 1 ? 32'(m_owner) : 0);
    check("timeout", 32'(timeout), 32'(m_to));
    ten = (gnt != 0 && gnt == prev_gnt) ? ten + 1 : (gnt != 0 ? 1 : 0);
    prev_gnt = gnt;
    if (gnt != 0) check("tenure_max", 32'(ten <= MH), 1);
  endtask
  initial begin
    int to_cnt;
    logic [N-1:0] r;
    step('0, 1'b1);
    step('0, 1'b1);
    check("reset_gnt", 32'(gnt), 0);
    check("reset_to", 32'(timeout), 0);
    step(4'b0001, 1'b0);
    check("first_gnt", 32'(gnt), 32'h1);
    check("first_id", 32'(gnt_id), 0);
    step(4'b0001, 1'b0);
    step(4'b0001, 1'b0);
    step(4'b0000, 1'b0);
    check("release", 32'(gnt), 0);
    to_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step(4'b1111, 1'b0);
      to_cnt += int'(timeout);
      check("no_gap", 32'(gnt_valid), 1);
    end
    check("full_load_timeouts", 32'(to_cnt), 4);
    step('0, 1'b1);
    for (int i = 0; i < 10; i++) step(4'b0100, 1'b0);
    check("park_gnt", 32'(gnt), 0);
    check("park_to", 32'(timeout), 1);
    step(4'b0100, 1'b0);
    check("regrant", 32'(gnt), 32'h4);
    step('0, 1'b1);
    for (int i = 0; i < 4; i++) step(4'b1010, 1'b0);
    check("own1", 32'(gnt), 32'h2);
    step(4'b1000, 1'b0);
    check("limit_release_gnt", 32'(gnt), 32'h8);
    check("limit_release_to", 32'(timeout), 0);
    step('0, 1'b1);
    step(4'b0100, 1'b0);
    step(4'b0100, 1'b0);
    step(4'b0100, 1'b1);
    check("mid_reset", 32'(gnt), 0);
    step(4'b1100, 1'b0);
    check("ptr_after_reset", 32'(gnt), 32'h4);
    r = '0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(3, 0) == 0) r = N'($urandom);
      step(r, $urandom_range(80, 0) == 0);
    end
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
